// File: rtl/test_harness.sv
// Processor self-test harness: runs the core for a cycle budget, then scans the
// register file through read port A and compares each register with a synchronous ROM.
module test_harness #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int CYC_W    = 16,
   localparam int REG_AW  = $clog2(NUM_REGS),
   localparam int EC_W    = $clog2(NUM_REGS + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CYC_W-1:0]  num_cycles,
   input  logic [REG_AW-1:0] cpu_rs1,
   output logic [REG_AW-1:0] rs1_out,
   input  logic [DATA_W-1:0] reg_data,
   output logic [REG_AW-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic              rwe,
   input  logic [REG_AW-1:0] rd,
   output logic              test_mode,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [EC_W-1:0]   error_count,
   output logic              first_fail_valid,
   output logic [REG_AW-1:0] first_fail_reg,
   output logic [CYC_W-1:0]  write_count,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   logic [CYC_W-1:0]    cyc_cnt;
   logic [EC_W-1:0]     scan_idx;
   logic [DATA_W-1:0]   stage_data;
   logic [REG_AW-1:0]   stage_idx;
   logic                stage_valid;

   // start is a single-cycle request with an implicit ready: it is taken on any
   // rising edge where the FSM sits in IDLE or DONE, and dropped otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cyc_cnt          <= '0;
         scan_idx         <= '0;
         stage_data       <= '0;
         stage_idx        <= '0;
         stage_valid      <= 1'b0;
         error_count      <= '0;
         first_fail_valid <= 1'b0;
         first_fail_reg   <= '0;
         write_count      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  error_count      <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_reg   <= '0;
                  write_count      <= '0;
                  cyc_cnt          <= num_cycles;
                  scan_idx         <= '0;
                  stage_valid      <= 1'b0;
                  state            <= (num_cycles == '0) ? SCAN : RUN;
               end
            end
            RUN: begin
               cyc_cnt <= cyc_cnt - CYC_W'(1);
               if (rwe && (rd != '0) && (write_count != '1))
                  write_count <= write_count + CYC_W'(1);
               if (cyc_cnt == CYC_W'(1)) begin
                  scan_idx    <= '0;
                  stage_valid <= 1'b0;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               // Issue stage captures register k while the ROM fetches address k;
               // compare stage checks the previous capture against the ROM output.
               if (scan_idx < EC_W'(NUM_REGS)) begin
                  stage_data  <= reg_data;
                  stage_idx   <= scan_idx[REG_AW-1:0];
                  stage_valid <= 1'b1;
                  scan_idx    <= scan_idx + EC_W'(1);
               end else begin
                  stage_valid <= 1'b0;
                  state       <= DONE;
               end
               if (stage_valid && (stage_data != exp_data)) begin
                  error_count <= error_count + EC_W'(1);
                  if (!first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_reg   <= stage_idx;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign test_mode = (state == SCAN);
   assign busy      = (state == RUN) || (state == SCAN);
   assign done      = (state == DONE);
   assign pass      = done && (error_count == '0);
   assign state_dbg = state;
   assign rs1_out   = test_mode ? scan_idx[REG_AW-1:0] : cpu_rs1;
   assign exp_addr  = test_mode ? scan_idx[REG_AW-1:0] : '0;

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: behavioural register file and synchronous ROM, randomized
// contents and write traffic, expected results computed from the run rules.
module tb_test_harness;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] num_cycles;
   logic [4:0]  cpu_rs1;
   logic [4:0]  rs1_out;
   logic [31:0] reg_data;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic        rwe;
   logic [4:0]  rd;
   logic        test_mode, busy, done, pass;
   logic [5:0]  error_count;
   logic        first_fail_valid;
   logic [4:0]  first_fail_reg;
   logic [15:0] write_count;
   logic [1:0]  state_dbg;

   logic [31:0] regs [32];
   logic [31:0] rom  [32];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   test_harness dut (
      .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
      .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .reg_data(reg_data),
      .exp_addr(exp_addr), .exp_data(exp_data), .rwe(rwe), .rd(rd),
      .test_mode(test_mode), .busy(busy), .done(done), .pass(pass),
      .error_count(error_count), .first_fail_valid(first_fail_valid),
      .first_fail_reg(first_fail_reg), .write_count(write_count),
      .state_dbg(state_dbg)
   );

   assign reg_data = regs[rs1_out];
   always @(posedge clock) exp_data <= rom[exp_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_test_mode"}, 64'(test_mode), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_pass"}, 64'(pass), 64'(0));
      check({tag, "_error_count"}, 64'(error_count), 64'(0));
      check({tag, "_ffv"}, 64'(first_fail_valid), 64'(0));
      check({tag, "_ffr"}, 64'(first_fail_reg), 64'(0));
      check({tag, "_write_count"}, 64'(write_count), 64'(0));
      check({tag, "_exp_addr"}, 64'(exp_addr), 64'(0));
      check({tag, "_rs1_pass"}, 64'(rs1_out), 64'(cpu_rs1));
   endtask

   // One complete run: nc RUN cycles, registers flagged in mask differ from the ROM.
   // abort_k >= 0 pulses reset during SCAN cycle abort_k instead of finishing.
   task automatic do_run(input string tag, input int nc, input int abort_k,
                         input bit directed, input logic [31:0] mask);
      int exp_err = 0;
      int exp_ffr = 0;
      int exp_wc  = 0;
      int k;
      bit run_bad  = 0;
      bit addr_bad = 0;
      for (int i = 0; i < 32; i++) begin
         regs[i] = $urandom;
         rom[i]  = regs[i];
      end
      for (int i = 31; i >= 0; i--) begin
         if (mask[i]) begin
            rom[i] = regs[i] ^ 32'(1 << $urandom_range(0, 31));
            exp_err++;
            exp_ffr = i;
         end
      end
      num_cycles = 16'(nc);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
      for (int i = 0; i < nc; i++) begin
         if (test_mode !== 1'b0 || busy !== 1'b1) run_bad = 1;
         if (directed) begin
            rwe = (i < 3);
            rd  = (i == 0) ? 5'd3 : (i == 1) ? 5'd0 : 5'd7;
         end else begin
            rwe = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
         end
         if (i == 1) begin
            start = 1'b1;
            num_cycles = 16'($urandom_range(0, 3));
         end
         if (rwe && rd != 5'd0 && exp_wc < 65535) exp_wc++;
         @(posedge clock); #1;
         start = 1'b0;
      end
      rwe = 1'b0;
      check({tag, "_run_length"}, 64'(run_bad), 64'(0));
      check({tag, "_scan_entry"}, 64'(test_mode), 64'(1));
      check({tag, "_write_count"}, 64'(write_count), 64'(exp_wc));
      cpu_rs1 = 5'($urandom_range(0, 31));
      k = 0;
      while (done !== 1'b1 && k < 100) begin
         if (k == abort_k) begin
            reset = 1'b1;
            #1;
            check_reset_values({tag, "_abort"});
            @(negedge clock);
            reset = 1'b0;
            repeat (3) @(posedge clock);
            #1;
            check({tag, "_no_restart_busy"}, 64'(busy), 64'(0));
            check({tag, "_no_restart_done"}, 64'(done), 64'(0));
            return;
         end
         if (k < 32 && (rs1_out !== 5'(k) || exp_addr !== 5'(k))) addr_bad = 1;
         @(posedge clock); #1;
         k++;
      end
      check({tag, "_scan_addr_seq"}, 64'(addr_bad), 64'(0));
      check({tag, "_scan_length"}, 64'(k), 64'(33));
      check({tag, "_done"}, 64'(done), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_pass"}, 64'(pass), 64'(exp_err == 0));
      check({tag, "_error_count"}, 64'(error_count), 64'(exp_err));
      check({tag, "_ffv"}, 64'(first_fail_valid), 64'(exp_err != 0));
      check({tag, "_ffr"}, 64'(first_fail_reg), 64'(exp_ffr));
      check({tag, "_rs1_pass"}, 64'(rs1_out), 64'(cpu_rs1));
      repeat (4) @(posedge clock);
      #1;
      check({tag, "_hold_error_count"}, 64'(error_count), 64'(exp_err));
      check({tag, "_hold_write_count"}, 64'(write_count), 64'(exp_wc));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      num_cycles = '0;
      cpu_rs1 = 5'd9;
      rwe = 1'b0;
      rd = '0;
      for (int i = 0; i < 32; i++) begin
         regs[i] = '0;
         rom[i]  = '0;
      end
      repeat (2) @(posedge clock);
      #1;
      check_reset_values("reset");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      do_run("five_cycles", 5, -1, 1'b1, 32'h0);
      do_run("fail_4_31", $urandom_range(1, 20), -1, 1'b0, 32'h8000_0010);
      do_run("zero_cycles", 0, -1, 1'b0, 32'h0);
      do_run("abort_scan", 6, 10, 1'b0, 32'h0000_0400);
      for (int t = 0; t < 4; t++)
         do_run("random", $urandom_range(0, 40), -1, 1'b0, $urandom);
      do_run("r0_only", 3, -1, 1'b0, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL timeout observed=running expected=finished");
   end

endmodule

// File: doc/test_harness.md
TEST_HARNESS -- requirements
Module: test_harness

Interface
REQ-001 Parameter DATA_W, default 32: register data width.
REQ-002 Parameter NUM_REGS, default 32: registers scanned; REG_AW = clog2(NUM_REGS).
REQ-003 Parameter CYC_W, default 16: width of cycle budget and write counter.
REQ-004 Port clock, in, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, in, 1: asynchronous, active-high; takes effect immediately, independent of clock.
REQ-006 Port start, in, 1: begins a run when sampled high in IDLE or DONE.
REQ-007 Port num_cycles, in, CYC_W: processor cycles to run; sampled on accepted start.
REQ-008 Port cpu_rs1, in, REG_AW: processor's read-port-A register select.
REQ-009 Port rs1_out, out, REG_AW: select driven to regfile port A; equals cpu_rs1 when test_mode=0, otherwise scan index.
REQ-010 Port reg_data, in, DATA_W: regfile port A data; combinational from rs1_out.
REQ-011 Port exp_addr, out, REG_AW: expected-value ROM address.
REQ-012 Port exp_data, in, DATA_W: ROM data; valid one cycle after exp_addr (synchronous ROM).
REQ-013 Ports rwe (1), rd (REG_AW), in: processor write-enable and destination monitor.
REQ-014 Port test_mode, out, 1: high only in SCAN.
REQ-015 Ports busy, done, pass, out, 1 each: status.
REQ-016 Port error_count, out, clog2(NUM_REGS+1): mismatching registers.
REQ-017 Ports first_fail_valid (1), first_fail_reg (REG_AW), out: lowest mismatching register.
REQ-018 Port write_count, out, CYC_W: cycles in RUN with rwe=1 and rd!=0.

Function
REQ-019 FSM states IDLE, RUN, SCAN, DONE; busy=1 in RUN and SCAN only; done=1 in DONE only.
REQ-020 Accepted start clears error_count, first_fail_valid, first_fail_reg, write_count and loads cycle counter with num_cycles.
REQ-021 IDLE/DONE + start=1 -> RUN; if num_cycles=0 -> SCAN directly, RUN skipped.
REQ-022 RUN: counter decrements each edge; after exactly num_cycles edges in RUN -> SCAN.
REQ-023 RUN: each edge with rwe=1 and rd!=0 increments write_count; saturates at all-ones.
REQ-024 start is ignored in RUN and SCAN.
REQ-025 SCAN issue: cycle k (k=0..NUM_REGS-1) drives rs1_out=exp_addr=k; reg_data captured into stage register with index k.
REQ-026 SCAN compare: cycle k+1 compares captured value with exp_data; mismatch increments error_count and, if first_fail_valid=0, sets first_fail_reg=k, first_fail_valid=1.
REQ-027 SCAN lasts exactly NUM_REGS+1 cycles (one drain cycle), then -> DONE; all registers including r0 are compared.
REQ-028 pass = done and error_count=0; pass=0 outside DONE.
REQ-029 DONE holds all results stable until next accepted start; start in DONE restarts per REQ-020/021.
REQ-030 rs1_out switches combinationally with test_mode; no extra latency on pass-through path.

Reset
REQ-031 reset=1 forces IDLE, test_mode=0, busy=0, done=0, pass=0, error_count=0, first_fail_valid=0, first_fail_reg=0, write_count=0, exp_addr=0, cycle counter=0.
REQ-032 reset asserted mid-RUN or mid-SCAN aborts; no partial result retained; start needed after release.

Verification
REQ-033 num_cycles=5, rwe=1 with rd=3,0,7 in three RUN cycles -> write_count=2; SCAN entered after 5 RUN edges.
REQ-034 ROM equals regfile for all 32 regs -> SCAN 33 cycles, done=1, pass=1, error_count=0, first_fail_valid=0.
REQ-035 Mismatch at regs 4 and 31 -> error_count=2, first_fail_reg=4, pass=0.
REQ-036 num_cycles=0 -> test_mode rises the edge after start; done after 33 further cycles.
REQ-037 reset pulsed during SCAN at k=10 -> all outputs at reset values immediately; rs1_out follows cpu_rs1.
REQ-038 start pulsed during RUN ignored; start in DONE clears counters and restarts with new num_cycles.
